op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
- Programmable instruction sequencer that sits directly upstream of the register-bank/ALU datapath stage and drives its 3-bit `op` input.
- Holds a small program of 3-bit ops, each with a halt flag.
- Fetches and issues one op at a time, holds each op stable for a settle window so the datapath can complete its write-back, and reports progress and completion.

Parameters:
- DEPTH, 8, number of program entries; power of two, 2..256.
- AW, 3, address width; equals log2(DEPTH).
- SETTLE_CYCLES, 1, cycles `op` is held after the issue cycle; minimum 1, maximum 15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- prog_we  input  1  program memory write enable.
- prog_addr  input  AW  program write address.
- prog_data  input  4  bit3 = halt flag, bits2:0 = op.
- start  input  1  begin execution from address 0.
- stop  input  1  abort execution.
- op  output  3  op presented to the datapath stage.
- op_valid  output  1  one-cycle pulse marking a newly issued op.
- pc  output  AW  address of the current instruction.
- busy  output  1  high while executing.
- done  output  1  high after execution ends, until the next start.
- instr_count  output  16  ops retired in the current run.

Behaviour:
- Reset (synchronous, active-high; one clock and one reset only):
  - state = IDLE.
  - op = 0, op_valid = 0, pc = 0, busy = 0, done = 0, instr_count = 0.
  - Every program entry is cleared to 4'b1000 (halt).
  - Reset mid-run aborts immediately; no DONE state is entered.
- All outputs are registered.
- States: IDLE, FETCH, CHECK, ISSUE, SETTLE, DONE.
- IDLE / DONE:
  - prog_we writes prog_data to mem[prog_addr].
  - start causes: pc <= 0, instr_count <= 0, done <= 0, busy <= 1, next state FETCH.
  - stop has no effect in these states; start wins if start and stop are both high.
- Busy states (FETCH..SETTLE):
  - prog_we is ignored; memory is unchanged.
  - start is ignored.
- FETCH: instr_r <= mem[pc]; next state CHECK.
- CHECK:
  - If instr_r[3] = 1: go to DONE; op is unchanged; no retire.
  - Otherwise: op <= instr_r[2:0]; go to ISSUE.
- ISSUE:
  - op_valid = 1 for exactly this one cycle.
  - Settle counter loaded with SETTLE_CYCLES; next state SETTLE.
- SETTLE:
  - op held; counter decrements each cycle.
  - On the last settle cycle the instruction retires:
    - instr_count increments, saturating at 16'hFFFF.
    - If pc = DEPTH-1: go to DONE (end of memory); pc is not incremented.
    - Otherwise: pc <= pc+1; go to FETCH.
- DONE: busy = 0, done = 1; op and pc hold their last values; op_valid = 0.
- stop while busy:
  - Next state is DONE, regardless of current state.
  - If stop arrives in ISSUE or SETTLE, that instruction counts as retired.
  - If stop arrives in FETCH or CHECK, nothing is retired.
  - No further op_valid pulses.
- Timing, with start sampled at edge N:
  - FETCH at N+1, CHECK at N+2, first op_valid high at N+3.
  - Per-instruction period: 3 + SETTLE_CYCLES cycles.
  - Halt at address 0: done = 1 at N+3, instr_count = 0.

Optional Feature:
- Macro: OP_SEQ_LOOP_EN.
- Defined: retiring the instruction at pc = DEPTH-1 wraps pc to 0 and continues with FETCH. Only the halt flag, stop or rst end the run. instr_count keeps accumulating, saturating.
- Not defined: end of memory goes to DONE, as described under Behaviour.

Test Plan:
- Reset then start with an empty program: done = 1 three cycles after the start edge; op_valid never pulses; instr_count = 0; op = 0.
- Load 3'b001, 3'b010, 3'b011, 3'b100 at addresses 0-3 and halt at 4, SETTLE_CYCLES = 1: four op_valid pulses 4 cycles apart carrying op 1, 2, 3, 4. Then done = 1, instr_count = 4, pc = 4.
- DEPTH = 8, no halt flag anywhere: eight pulses, then done; pc = 7, instr_count = 8.
- stop in the SETTLE state of the 2nd instruction: DONE on the next cycle; instr_count = 2; no third pulse; busy = 0.
- prog_we to address 1 with data 4'b0111 while busy: write ignored. Rerun issues the original op at address 1.
- rst asserted mid-run: next cycle all outputs are at reset values and memory is all halts. Separately, with OP_SEQ_LOOP_EN and DEPTH = 4 without halts, stop after 10 pulses: pc wraps 3 -> 0 and instr_count = 10.

Source files
------------

// File: rtl/op_sequencer.sv
// Programmable op sequencer feeding the register-bank/ALU stage: fetches 4-bit
// entries (halt flag + 3-bit op) and holds each issued op for a settle window.
// Optional wrap-around looping at end of memory is enabled by OP_SEQ_LOOP_EN.
module op_sequencer #(
  parameter int DEPTH         = 8,
  parameter int AW            = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [3:0]    prog_data,
  input  logic          start,
  input  logic          stop,
  output logic [2:0]    op,
  output logic          op_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, ISSUE, SETTLE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  mem [DEPTH];
  logic [3:0]  instr_r;
  logic [3:0]  settle_cnt;
  logic        retire;
  logic        pc_adv;
  logic        settle_last;
  logic        run_active;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign settle_last = (settle_cnt == 4'd1);
  assign run_active  = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    pc_adv    = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = FETCH;
      FETCH:      state_nxt = stop ? DONE : CHECK;
      CHECK:      state_nxt = (stop || instr_r[3]) ? DONE : ISSUE;
      ISSUE: begin
        // An op already on the bus when stop arrives still counts as retired.
        if (stop) begin
          state_nxt = DONE;
          retire    = 1'b1;
        end else begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) begin
          state_nxt = DONE;
          retire    = 1'b1;
        end else if (settle_last) begin
          retire = 1'b1;
`ifdef OP_SEQ_LOOP_EN
          pc_adv    = 1'b1;
          state_nxt = FETCH;
`else
          if (pc == AW'(DEPTH - 1)) begin
            state_nxt = DONE;
          end else begin
            pc_adv    = 1'b1;
            state_nxt = FETCH;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op          <= 3'd0;
      op_valid    <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_count <= 16'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'b1000;
    end else begin
      op_valid <= (state == CHECK) && (state_nxt == ISSUE);
      if (!run_active) begin
        if (prog_we) mem[prog_addr] <= prog_data;
        if (start) begin
          pc          <= '0;
          instr_count <= 16'd0;
          done        <= 1'b0;
          busy        <= 1'b1;
        end
      end
      if ((state == CHECK) && (state_nxt == ISSUE)) op <= instr_r[2:0];
      if (retire) instr_count <= sat_inc(instr_count);
      if (pc_adv) pc <= pc + 1'b1;
      if (run_active && (state_nxt == DONE)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Fetch latch and settle timer need no reset: both are loaded before use.
  always_ff @(posedge clk) begin
    if (state == FETCH) instr_r <= mem[pc];
    if (state == ISSUE)       settle_cnt <= 4'(SETTLE_CYCLES);
    else if (state == SETTLE) settle_cnt <= settle_cnt - 4'd1;
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: stimulus queues expected ops, a monitor
// checks every op_valid pulse (value and spacing) against the queue.
module tb_op_sequencer;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int SETTLE = 1;

  logic          clk = 1'b0;
  logic          rst, prog_we, start, stop;
  logic [AW-1:0] prog_addr;
  logic [3:0]    prog_data;
  logic [2:0]    op;
  logic          op_valid;
  logic [AW-1:0] pc;
  logic          busy, done;
  logic [15:0]   instr_count;

  op_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stop(stop), .op(op),
    .op_valid(op_valid), .pc(pc), .busy(busy), .done(done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  int         cyc      = 0;
  int         last_cyc = 0;
  bit         run_first = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every issued op must match the next queued expectation.
  always @(negedge clk) begin
    if (op_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_op_valid: got op %0d, expected no pulse", op);
      end else begin
        chk("issued_op", 32'(op), 32'(exp_q.pop_front()));
        if (!run_first) chk("pulse_gap", 32'(cyc - last_cyc), 32'(3 + SETTLE));
        run_first = 1'b0;
        last_cyc  = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    run_first = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [3:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int i = 0;
    while (done !== 1'b1 && i < max) begin
      tick();
      i++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

`ifdef OP_SEQ_LOOP_EN
  logic       lp_we, lp_start, lp_stop;
  logic [1:0] lp_addr;
  logic [3:0] lp_data;
  logic [2:0] lp_op;
  logic       lp_valid, lp_busy, lp_done;
  logic [1:0] lp_pc;
  logic [15:0] lp_count;

  op_sequencer #(.DEPTH(4), .AW(2), .SETTLE_CYCLES(SETTLE)) lp (
    .clk(clk), .rst(rst), .prog_we(lp_we), .prog_addr(lp_addr),
    .prog_data(lp_data), .start(lp_start), .stop(lp_stop), .op(lp_op),
    .op_valid(lp_valid), .pc(lp_pc), .busy(lp_busy), .done(lp_done),
    .instr_count(lp_count)
  );
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; prog_we = 1'b0; start = 1'b0; stop = 1'b0;
    prog_addr = '0; prog_data = '0;
`ifdef OP_SEQ_LOOP_EN
    lp_we = 1'b0; lp_start = 1'b0; lp_stop = 1'b0; lp_addr = '0; lp_data = '0;
`endif
    repeat (3) tick();
    chk("rst_op", 32'(op), 0);
    chk("rst_op_valid", 32'(op_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(instr_count), 0);
    rst = 1'b0;
    tick();

    // Empty program: halt at address 0.
    do_start();
    tick();
    chk("empty_done_early", 32'(done), 0);
    chk("empty_busy", 32'(busy), 1);
    tick();
    chk("empty_done", 32'(done), 1);
    chk("empty_count", 32'(instr_count), 0);
    chk("empty_op", 32'(op), 0);
    chk("empty_busy_low", 32'(busy), 0);
    tick();

    // Four ops then halt.
    for (int i = 0; i < 4; i++) write(AW'(i), 4'(i + 1));
    write(3'd4, 4'b1000);
    for (int i = 0; i < 4; i++) exp_q.push_back(3'(i + 1));
    do_start();
    tick(); tick();
    chk("first_issue_latency", 32'(op_valid), 1);
    chk("first_issue_op", 32'(op), 1);
    wait_done("prog4_done", 40);
    chk("prog4_count", 32'(instr_count), 4);
    chk("prog4_pc", 32'(pc), 4);
    chk("prog4_op_held", 32'(op), 4);
    chk("prog4_queue_empty", 32'(exp_q.size()), 0);
    tick();

    // stop in SETTLE of the second instruction.
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    do_start();
    repeat (6) tick();
    chk("second_issue", 32'(op_valid), 1);
    chk("second_issue_op", 32'(op), 2);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_done", 32'(done), 1);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_count", 32'(instr_count), 2);
    repeat (10) tick();
    chk("stop_count_stable", 32'(instr_count), 2);
    chk("stop_queue_empty", 32'(exp_q.size()), 0);

    // Write while busy must be ignored; rerun shows the original op.
    for (int i = 0; i < 4; i++) exp_q.push_back(3'(i + 1));
    do_start();
    tick();
    write(3'd1, 4'b0111);
    wait_done("busywr_done", 40);
    chk("busywr_count", 32'(instr_count), 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(3'(i + 1));
    do_start();
    wait_done("rerun_done", 40);
    chk("rerun_count", 32'(instr_count), 4);
    chk("rerun_queue_empty", 32'(exp_q.size()), 0);
    tick();

`ifndef OP_SEQ_LOOP_EN
    // No halt anywhere: runs to end of memory.
    write(3'd4, 4'd5); write(3'd5, 4'd6); write(3'd6, 4'd7); write(3'd7, 4'd0);
    for (int i = 1; i <= 7; i++) exp_q.push_back(3'(i));
    exp_q.push_back(3'd0);
    do_start();
    wait_done("full_done", 80);
    chk("full_pc", 32'(pc), 7);
    chk("full_count", 32'(instr_count), 8);
    chk("full_op", 32'(op), 0);
    chk("full_queue_empty", 32'(exp_q.size()), 0);
    tick();
`endif

    // Reset mid-run.
    for (int i = 0; i < 4; i++) exp_q.push_back(3'(i + 1));
    do_start();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("midrst_op", 32'(op), 0);
    chk("midrst_op_valid", 32'(op_valid), 0);
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_count", 32'(instr_count), 0);
    rst = 1'b0;
    tick();
    write(3'd0, 4'd3);
    exp_q.push_back(3'd3);
    do_start();
    wait_done("postrst_done", 20);
    chk("postrst_count", 32'(instr_count), 1);
    chk("postrst_pc", 32'(pc), 1);
    chk("postrst_queue_empty", 32'(exp_q.size()), 0);

`ifdef OP_SEQ_LOOP_EN
    begin
      int pulses = 0;
      int guard  = 0;
      for (int i = 0; i < 4; i++) begin
        lp_addr = 2'(i); lp_data = 4'(i + 1); lp_we = 1'b1;
        tick();
      end
      lp_we = 1'b0;
      lp_start = 1'b1;
      tick();
      lp_start = 1'b0;
      while (pulses < 10 && guard < 200) begin
        tick();
        guard++;
        if (lp_valid === 1'b1) pulses++;
      end
      chk("loop_pulses", 32'(pulses), 10);
      lp_stop = 1'b1;
      tick();
      lp_stop = 1'b0;
      chk("loop_done", 32'(lp_done), 1);
      chk("loop_count", 32'(lp_count), 10);
      chk("loop_pc_wrapped", 32'(lp_pc), 1);
    end
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
